// File: rtl/vector_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vector_sequencer                                           |
// | Description : Exhaustive 3-input stimulus sequencer. It applies all 8    |
// |               vectors to a combinational stage and waits SETTLE cycles   |
// |               after each one. It then compares y with a golden table and |
// |               reports pass and a mismatch count.                         |
// | Options     : STOP_ON_FAIL_EN - end the run at the first mismatch        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module vector_sequencer #(
    parameter int unsigned SETTLE   = 4,
    parameter logic [7:0]  EXPECTED = 8'h33
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       y,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_count,
    output logic [2:0] vec_idx
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_APPLY  = 3'd1;
    localparam logic [2:0] c_ST_SETTLE = 3'd2;
    localparam logic [2:0] c_ST_CHECK  = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    localparam logic       c_NO_SETTLE   = (SETTLE == 0);
    // The counter runs down to zero, so it is loaded with one less than the hold length.
    localparam logic [3:0] c_SETTLE_LOAD = (SETTLE == 0) ? 4'd0 : 4'(SETTLE - 1);

    logic [2:0] r_state;
    logic [2:0] w_next_state;
    logic [2:0] r_abc;
    logic [2:0] r_vec_idx;
    logic [3:0] r_err_count;
    logic       r_pass;
    logic [3:0] r_settle_cnt;
    logic       w_mismatch;

    assign w_mismatch = y ^ EXPECTED[r_vec_idx];

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) w_next_state = c_ST_APPLY;
            end
            c_ST_APPLY: begin
                w_next_state = c_NO_SETTLE ? c_ST_CHECK : c_ST_SETTLE;
            end
            c_ST_SETTLE: begin
                if (r_settle_cnt == 4'd0) w_next_state = c_ST_CHECK;
            end
            c_ST_CHECK: begin
`ifdef STOP_ON_FAIL_EN
                if (w_mismatch || (r_vec_idx == 3'd7)) w_next_state = c_ST_DONE;
                else                                    w_next_state = c_ST_APPLY;
`else
                if (r_vec_idx == 3'd7) w_next_state = c_ST_DONE;
                else                   w_next_state = c_ST_APPLY;
`endif
            end
            c_ST_DONE: begin
                w_next_state = c_ST_IDLE;
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_abc        <= 3'd0;
            r_vec_idx    <= 3'd0;
            r_err_count  <= 4'd0;
            r_pass       <= 1'b0;
            r_settle_cnt <= 4'd0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_vec_idx   <= 3'd0;
                        r_err_count <= 4'd0;
                        r_pass      <= 1'b0;
                    end
                end
                c_ST_APPLY: begin
                    r_abc        <= r_vec_idx;
                    r_settle_cnt <= c_SETTLE_LOAD;
                end
                c_ST_SETTLE: begin
                    if (r_settle_cnt != 4'd0) r_settle_cnt <= r_settle_cnt - 4'd1;
                end
                c_ST_CHECK: begin
                    // At most eight checks happen per run, so the 4-bit count cannot wrap.
                    if (w_mismatch) r_err_count <= r_err_count + 4'd1;
                    if (w_next_state == c_ST_APPLY) r_vec_idx <= r_vec_idx + 3'd1;
                end
                c_ST_DONE: begin
                    r_pass <= (r_err_count == 4'd0);
                end
                default: begin
                end
            endcase
        end
    end

    assign a         = r_abc[2];
    assign b         = r_abc[1];
    assign c         = r_abc[0];
    assign busy      = (r_state != c_ST_IDLE);
    assign done      = (r_state == c_ST_DONE);
    assign pass      = r_pass;
    assign err_count = r_err_count;
    assign vec_idx   = r_vec_idx;

endmodule
`default_nettype wire

// File: tb/tb_vector_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vector_sequencer                                        |
// | Description : Scoreboard bench for vector_sequencer (SETTLE=4 and 0).    |
// |               Honours STOP_ON_FAIL_EN when it is defined.                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_vector_sequencer;

    localparam int unsigned c_SETTLE_A = 4;
    localparam int unsigned c_SETTLE_B = 0;
    localparam logic [7:0]  c_GOLDEN   = 8'h33;

    typedef struct {
        int         done_cyc;
        int         err;
        int         idx;
        int         pass;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] start;
    logic [1:0] y;
    logic [1:0] a, b, c, busy, done, pass;
    logic [3:0] err_count [2];
    logic [2:0] vec_idx   [2];
    logic [7:0] tt        [2];

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stage under test: an arbitrary truth table indexed by {a,b,c}.
    assign y[0] = tt[0][{a[0], b[0], c[0]}];
    assign y[1] = tt[1][{a[1], b[1], c[1]}];

    vector_sequencer #(.SETTLE(c_SETTLE_A), .EXPECTED(c_GOLDEN)) u_dut_a (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .y(y[0]),
        .a(a[0]), .b(b[0]), .c(c[0]), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .err_count(err_count[0]), .vec_idx(vec_idx[0])
    );

    vector_sequencer #(.SETTLE(c_SETTLE_B), .EXPECTED(c_GOLDEN)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .y(y[1]),
        .a(a[1]), .b(b[1]), .c(c[1]), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .err_count(err_count[1]), .vec_idx(vec_idx[1])
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (time %0t)", name, act, exp, $time);
        end
    endtask

    function automatic int settle_of(input int i);
        return (i == 0) ? int'(c_SETTLE_A) : int'(c_SETTLE_B);
    endfunction

    // Outcome of one run, derived from the golden table and the stage table.
    function automatic exp_t model(input int s, input int start_edge, input logic [7:0] tbl);
        exp_t       e;
        logic [7:0] gold;
        int         errs;
        int         first;
        gold  = c_GOLDEN;
        errs  = 0;
        first = -1;
        for (int v = 0; v < 8; v++) begin
            if (tbl[v] != gold[v]) begin
                errs++;
                if (first < 0) first = v;
            end
        end
        e.err      = errs;
        e.idx      = 7;
        e.done_cyc = start_edge + 8 * (s + 2);
        e.pass     = (errs == 0) ? 1 : 0;
`ifdef STOP_ON_FAIL_EN
        if (first >= 0) begin
            e.err      = 1;
            e.idx      = first;
            e.done_cyc = start_edge + (first + 1) * (s + 2);
            e.pass     = 0;
        end
`endif
        return e;
    endfunction

    function automatic void push(input int i, input exp_t e);
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t qpop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic run(input int i, input logic [7:0] tbl, input bit pulse_mid);
        exp_t e;
        @(negedge clk);
        tt[i]    = tbl;
        start[i] = 1'b1;
        e = model(settle_of(i), cyc + 1, tbl);
        push(i, e);
        @(negedge clk);
        start[i] = 1'b0;
        if (pulse_mid) begin
            repeat (5) @(negedge clk);
            start[i] = 1'b1;
            @(negedge clk);
            start[i] = 1'b0;
        end
        while (cyc < e.done_cyc + 4) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input int i, input string tag);
        check({tag, "_a"},       a[i],         0);
        check({tag, "_b"},       b[i],         0);
        check({tag, "_c"},       c[i],         0);
        check({tag, "_busy"},    busy[i],      0);
        check({tag, "_done"},    done[i],      0);
        check({tag, "_pass"},    pass[i],      0);
        check({tag, "_err"},     err_count[i], 0);
        check({tag, "_vec_idx"}, vec_idx[i],   0);
    endtask

    // Monitor: compares each done pulse with the oldest expectation for that instance.
    initial begin
        exp_t       e;
        exp_t       pend_e [2];
        logic [1:0] pend;
        pend = 2'b00;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (pend[i]) begin
                    check("pass_after_done", pass[i], pend_e[i].pass);
                    check("done_one_cycle", done[i], 0);
                    check("abc_hold", {a[i], b[i], c[i]}, pend_e[i].idx);
                    check("err_hold", err_count[i], pend_e[i].err);
                    pend[i] = 1'b0;
                end else if (done[i]) begin
                    if (qsize(i) == 0) begin
                        check("unexpected_done", done[i], 0);
                    end else begin
                        e = qpop(i);
                        check("done_cycle", cyc, e.done_cyc);
                        check("err_count", err_count[i], e.err);
                        check("vec_idx", vec_idx[i], e.idx);
                        check("abc_at_done", {a[i], b[i], c[i]}, e.idx);
                        check("busy_at_done", busy[i], 1);
                        pend_e[i] = e;
                        pend[i]   = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e1;
        exp_t e2;
        int   s0;
        reset_n = 1'b0;
        start   = 2'b00;
        tt[0]   = c_GOLDEN;
        tt[1]   = c_GOLDEN;
        s0      = settle_of(0);
        repeat (3) @(negedge clk);
        check_reset_outputs(0, "rst0");
        check_reset_outputs(1, "rst1");
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run(0, c_GOLDEN, 1'b0);
        run(0, 8'h00, 1'b0);
        run(1, c_GOLDEN, 1'b1);
        run(1, 8'h00, 1'b0);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] tbl;
            tbl = ($urandom_range(0, 2) == 0) ? c_GOLDEN : 8'($urandom);
            run(k % 2, tbl, 1'b0);
        end

        // Start held high across two back-to-back runs.
        @(negedge clk);
        tt[0]    = 8'h00;
        start[0] = 1'b1;
        e1 = model(s0, cyc + 1, 8'h00);
        e2 = model(s0, e1.done_cyc + 2, 8'h00);
        push(0, e1);
        push(0, e2);
        while (cyc < e1.done_cyc + 2) @(negedge clk);
        start[0] = 1'b0;
        while (cyc < e2.done_cyc + 4) @(negedge clk);

        // Reset during the settle phase of vector 3 aborts the run.
        @(negedge clk);
        tt[0]    = c_GOLDEN;
        start[0] = 1'b1;
        e1 = model(s0, cyc + 1, c_GOLDEN);
        push(0, e1);
        @(negedge clk);
        start[0] = 1'b0;
        while (cyc < e1.done_cyc - 8 * (s0 + 2) + 3 * (s0 + 2) + 2) @(negedge clk);
        check("midrun_busy", busy[0], 1);
        check("midrun_vec_idx", vec_idx[0], 3);
        reset_n = 1'b0;
        #1;
        check_reset_outputs(0, "abort");
        void'(q0.pop_back());
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        run(0, c_GOLDEN, 1'b0);

        repeat (5) @(negedge clk);
        check("pending_a", q0.size(), 0);
        check("pending_b", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
